// File: rtl/mos6502_bus_responder_pkg.sv
// Shared definitions for the mos6502 bus responder: register offsets,
// control/status bit positions, wait-FSM states, vector and open-bus values.
package mos6502_bus_responder_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IO_OFF_W = 3;
    localparam int unsigned WCNT_W   = 4;

    // I/O register offsets from IO_BASE
    localparam logic [IO_OFF_W-1:0] OFF_TLO  = 3'd0;
    localparam logic [IO_OFF_W-1:0] OFF_THI  = 3'd1;
    localparam logic [IO_OFF_W-1:0] OFF_CTRL = 3'd2;
    localparam logic [IO_OFF_W-1:0] OFF_STAT = 3'd3;
    localparam logic [IO_OFF_W-1:0] OFF_WDOG = 3'd4;

    // CTRL / STAT bit indices
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_IE   = 1;
    localparam int unsigned CTRL_AUTO = 2;
    localparam int unsigned STAT_PEND = 0;

    // Vector block starts at the NMI vector and runs to $FFFF
    localparam logic [ADDR_W-1:0] VEC_BASE = 16'hFFFA;

    // Value returned for unmapped reads and in reset
    localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } wait_state_e;

endpackage

// File: rtl/mos6502_bus_responder_if.sv
// CPU-side bus bundle: the CPU is the master, the responder is the slave.
interface mos6502_bus_responder_if;
    import mos6502_bus_responder_pkg::*;

    logic [ADDR_W-1:0] add_bus;
    logic [DATA_W-1:0] d_out;
    logic              write_en;
    logic [DATA_W-1:0] d_in;
    logic              rdy;
    logic              IRQ;
    logic              NMI;

    modport master (
        output add_bus, d_out, write_en,
        input  d_in, rdy, IRQ, NMI
    );

    modport slave (
        input  add_bus, d_out, write_en,
        output d_in, rdy, IRQ, NMI
    );

endinterface

// File: rtl/mos6502_timer16.sv
// 16-bit interval timer: reload/count registers, EN/IE/AUTO control,
// sticky PEND flag and the active-low interrupt derived from it.
module mos6502_timer16
    import mos6502_bus_responder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_stb,
    input  logic [IO_OFF_W-1:0] off,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data_c,
    output logic                irq_c
);

    logic [15:0] reload;
    logic [15:0] count;
    logic [2:0]  ctrl;
    logic        pend;
    logic        wr_ctrl;
    logic        set_pend;
    logic        clr_pend;

    // Strobe decode; a CTRL write takes priority over expiry in that cycle
    always_comb begin
        wr_ctrl  = wr_stb && (off == OFF_CTRL);
        clr_pend = wr_stb && (off == OFF_STAT) && wr_data[STAT_PEND];
        set_pend = !wr_ctrl && ctrl[CTRL_EN] && (count == 16'd0);
    end

    // Reload register bytes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload <= '0;
        end else if (wr_stb && (off == OFF_TLO)) begin
            reload[7:0] <= wr_data;
        end else if (wr_stb && (off == OFF_THI)) begin
            reload[15:8] <= wr_data;
        end
    end

    // Control register and down-counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl  <= '0;
            count <= '0;
        end else if (wr_ctrl) begin
            ctrl <= wr_data[2:0];
            if (wr_data[CTRL_EN]) begin
                count <= reload;
            end
        end else if (ctrl[CTRL_EN]) begin
            if (count == 16'd0) begin
                if (ctrl[CTRL_AUTO]) begin
                    count <= reload;
                end else begin
                    ctrl[CTRL_EN] <= 1'b0;
                end
            end else begin
                count <= count - 16'd1;
            end
        end
    end

    // Pending flag; a simultaneous set beats the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if (set_pend) begin
            pend <= 1'b1;
        end else if (clr_pend) begin
            pend <= 1'b0;
        end
    end

    // Register read mux and interrupt level
    always_comb begin
        rd_data_c = 8'h00;
        case (off)
            OFF_TLO:  rd_data_c = count[7:0];
            OFF_THI:  rd_data_c = count[15:8];
            OFF_CTRL: rd_data_c = {5'b0, ctrl};
            OFF_STAT: rd_data_c = {7'b0, pend};
            default:  rd_data_c = 8'h00;
        endcase
        irq_c = ~(pend & ctrl[CTRL_IE]);
    end

endmodule

// File: rtl/mos6502_bus_responder.sv
// Bus responder for a mos6502 CPU: zero-wait RAM, I/O window with
// wait-state stretching, interval timer (IRQ) and the fixed vector ROM.
// Optional watchdog on NMI is built when MOS6502_RESP_WDOG_EN is defined.
module mos6502_bus_responder
    import mos6502_bus_responder_pkg::*;
#(
    parameter int unsigned       RAM_AW       = 11,
    parameter logic [ADDR_W-1:0] IO_BASE      = 16'hD000,
    parameter int unsigned       WAIT_CYCLES  = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'hF000,
    parameter int unsigned       WDOG_CYCLES  = 65535
)(
    input  logic                   clk,
    input  logic                   reset,
    mos6502_bus_responder_if.slave bus
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                we_n;
    logic                ram_hit;
    logic                io_hit;
    logic                vec_hit;
    logic [IO_OFF_W-1:0] io_off;
    logic [DATA_W-1:0]   rd_sel_c;
    logic [DATA_W-1:0]   timer_rd_c;
    logic                irq_c;
    logic                rdy_c;
    logic                complete_c;
    logic                wr_c;
    wait_state_e         state;
    logic [WCNT_W-1:0]   wcnt;
    logic [DATA_W-1:0]   d_in_q;
    logic [DATA_W-1:0]   mem [RAM_DEPTH];

    assign addr  = bus.add_bus;
    assign wdata = bus.d_out;
    assign we_n  = bus.write_en;

    // Address decode and read-data select (RAM, then I/O, then vectors)
    always_comb begin
        ram_hit  = (addr >> RAM_AW) == '0;
        io_hit   = addr[ADDR_W-1:IO_OFF_W] == IO_BASE[ADDR_W-1:IO_OFF_W];
        vec_hit  = addr >= VEC_BASE;
        io_off   = addr[IO_OFF_W-1:0];
        rd_sel_c = OPEN_BUS;
        if (ram_hit) begin
            rd_sel_c = mem[addr[RAM_AW-1:0]];
        end else if (io_hit) begin
            rd_sel_c = timer_rd_c;
        end else if (vec_hit) begin
            rd_sel_c = addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
        end
    end

    // Wait-state FSM; the IDLE cycle counts as the first stall cycle, so
    // the WAIT state lasts WAIT_CYCLES-1 cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_hit && (WAIT_CYCLES != 0)) begin
                        if (WAIT_CYCLES == 1) begin
                            state <= ST_DONE;
                        end else begin
                            wcnt  <= WCNT_W'(WAIT_CYCLES - 2);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        wcnt <= wcnt - WCNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is combinational so an I/O access stalls in its first cycle
    always_comb begin
        rdy_c = 1'b1;
        case (state)
            ST_IDLE: rdy_c = !(io_hit && (WAIT_CYCLES != 0));
            ST_WAIT: rdy_c = 1'b0;
            ST_DONE: rdy_c = 1'b1;
            default: rdy_c = 1'b1;
        endcase
        if (!reset) begin
            rdy_c = 1'b1;
        end
        complete_c = rdy_c & reset;
        wr_c       = complete_c & ~we_n;
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_c && ram_hit) begin
            mem[addr[RAM_AW-1:0]] <= wdata;
        end
    end

    // Registered read data, updated on each completed access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_in_q <= OPEN_BUS;
        end else if (complete_c) begin
            d_in_q <= rd_sel_c;
        end
    end

    mos6502_timer16 u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_stb    (wr_c && io_hit),
        .off       (io_off),
        .wr_data   (wdata),
        .rd_data_c (timer_rd_c),
        .irq_c     (irq_c)
    );

    assign bus.d_in = d_in_q;
    assign bus.rdy  = rdy_c;
    assign bus.IRQ  = irq_c;

`ifdef MOS6502_RESP_WDOG_EN
    logic [15:0] wdog_cnt;
    logic [2:0]  pulse_cnt;
    logic        nmi_q;
    logic        kick;

    assign kick = wr_c && io_hit && (io_off == OFF_WDOG);

    // Watchdog: fixed 8-cycle NMI pulse on timeout, kicks ignored mid-pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt  <= 16'(WDOG_CYCLES);
            pulse_cnt <= '0;
            nmi_q     <= 1'b1;
        end else if (!nmi_q) begin
            if (pulse_cnt == 3'd0) begin
                nmi_q    <= 1'b1;
                wdog_cnt <= 16'(WDOG_CYCLES);
            end else begin
                pulse_cnt <= pulse_cnt - 3'd1;
            end
        end else if (kick) begin
            wdog_cnt <= 16'(WDOG_CYCLES);
        end else if (wdog_cnt <= 16'd1) begin
            nmi_q     <= 1'b0;
            pulse_cnt <= 3'd7;
        end else begin
            wdog_cnt <= wdog_cnt - 16'd1;
        end
    end

    assign bus.NMI = nmi_q;
`else
    logic wdog_unused;
    assign wdog_unused = ^16'(WDOG_CYCLES);
    assign bus.NMI     = 1'b1;
`endif

endmodule

// File: tb/tb_mos6502_bus_responder.sv
// Directed self-checking bench for mos6502_bus_responder.
module tb_mos6502_bus_responder;

`ifdef MOS6502_RESP_WDOG_EN
    localparam int unsigned WDOG_N = 16;
`else
    localparam int unsigned WDOG_N = 65535;
`endif
    localparam logic [15:0] IDLE_ADDR = 16'h0200;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic nmi_low_seen = 1'b0;

    mos6502_bus_responder_if bus_if ();

    mos6502_bus_responder #(
        .RAM_AW       (11),
        .IO_BASE      (16'hD000),
        .WAIT_CYCLES  (2),
        .RESET_VECTOR (16'hF000),
        .WDOG_CYCLES  (WDOG_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && (bus_if.NMI !== 1'b1)) nmi_low_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // Present one access, wait for rdy, return d_in after the completing edge
    task automatic bus_access(input logic [15:0] a, input logic we_n, input logic [7:0] wd,
                              output logic [7:0] rd, output int st);
        bus_if.add_bus  = a;
        bus_if.d_out    = wd;
        bus_if.write_en = we_n;
        st = 0;
        forever begin
            @(negedge clk);
            if (bus_if.rdy === 1'b1) break;
            st++;
            if (st > 32) begin
                checks++; errors++;
                $display("FAIL bus_timeout addr=%h: rdy still %b after %0d cycles, required 1", a, bus_if.rdy, st);
                break;
            end
        end
        @(posedge clk); #1;
        rd = bus_if.d_in;
        bus_if.add_bus  = IDLE_ADDR;
        bus_if.write_en = 1'b1;
        bus_if.d_out    = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] rd, output int st);
        bus_access(a, 1'b1, 8'h00, rd, st);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] wd, output int st);
        logic [7:0] dummy;
        bus_access(a, 1'b0, wd, dummy, st);
    endtask

    task automatic test_reset();
        bus_if.add_bus  = 16'hFFFC;
        bus_if.d_out    = 8'h00;
        bus_if.write_en = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        checks++; if (bus_if.d_in !== 8'hFF) begin errors++; $display("FAIL reset_d_in: got %h, expected ff", bus_if.d_in); end
        checks++; if (bus_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b, expected 1", bus_if.rdy); end
        checks++; if (bus_if.IRQ !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b, expected 1", bus_if.IRQ); end
        checks++; if (bus_if.NMI !== 1'b1) begin errors++; $display("FAIL reset_nmi: got %b, expected 1", bus_if.NMI); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_vector();
        logic [7:0] d; int st;
        bus_read(16'hFFFC, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL vec_lo: got %h, expected 00", d); end
        checks++; if (st !== 0) begin errors++; $display("FAIL vec_lo_stall: got %0d, expected 0", st); end
        bus_read(16'hFFFD, d, st);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL vec_hi: got %h, expected f0", d); end
        checks++; if (st !== 0) begin errors++; $display("FAIL vec_hi_stall: got %0d, expected 0", st); end
        bus_read(16'hFFFA, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL vec_nmi_lo: got %h, expected 00", d); end
        bus_read(16'hFFFF, d, st);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL vec_irq_hi: got %h, expected f0", d); end
    endtask

    task automatic test_ram();
        logic [7:0] d; int st;
        bus_write(16'h0123, 8'hA5, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL ram_wr_stall: got %0d, expected 0", st); end
        bus_read(16'h0123, d, st);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ram_rd: got %h, expected a5", d); end
        bus_read(16'h8000, d, st);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmapped_rd: got %h, expected ff", d); end
        checks++; if (st !== 0) begin errors++; $display("FAIL unmapped_stall: got %0d, expected 0", st); end
        bus_write(16'h0000, 8'h11, st);
        bus_write(16'h07FF, 8'h5A, st);
        bus_write(16'h0800, 8'h77, st);
        bus_read(16'h07FF, d, st);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL ram_top: got %h, expected 5a", d); end
        bus_read(16'h0800, d, st);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ram_above: got %h, expected ff", d); end
        bus_read(16'h0000, d, st);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL ram_no_alias: got %h, expected 11", d); end
        bus_write(16'hFFFC, 8'h12, st);
        bus_read(16'hFFFC, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rom_wr_dropped: got %h, expected 00", d); end
    endtask

    task automatic test_wait_states();
        logic [7:0] d; logic [5:0] pat; int st;
        bus_read(16'hD002, d, st);
        checks++; if (st !== 2) begin errors++; $display("FAIL io_stall: got %0d, expected 2", st); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL io_ctrl_rd: got %h, expected 00", d); end
        bus_if.add_bus  = 16'hD002;
        bus_if.write_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = bus_if.rdy;
        end
        @(posedge clk); #1;
        bus_if.add_bus = IDLE_ADDR;
        checks++; if (pat !== 6'b100100) begin errors++; $display("FAIL b2b_rdy_pattern: got %b, expected 100100", pat); end
        bus_read(16'hD005, d, st);
        checks++; if (st !== 2 || d !== 8'h00) begin errors++; $display("FAIL rmw_rd: got stall %0d data %h, expected 2 00", st, d); end
        bus_write(16'hD005, 8'h3C, st);
        checks++; if (st !== 2) begin errors++; $display("FAIL rmw_wr_stall: got %0d, expected 2", st); end
    endtask

    task automatic test_timer();
        logic [7:0] d; logic ok; int st;
        bus_write(16'hD000, 8'h03, st);
        bus_write(16'hD001, 8'h00, st);
        bus_write(16'hD002, 8'h03, st);
        ok = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (bus_if.IRQ !== 1'b1) ok = 1'b0; end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timer_early_irq: got early IRQ low, expected high 3 cycles"); end
        @(posedge clk); #1;
        checks++; if (bus_if.IRQ !== 1'b0) begin errors++; $display("FAIL timer_irq_4: got %b, expected 0", bus_if.IRQ); end
        bus_read(16'hD003, d, st);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL timer_stat: got %h, expected 01", d); end
        bus_read(16'hD002, d, st);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL timer_en_cleared: got %h, expected 02", d); end
        bus_read(16'hD000, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL timer_count_end: got %h, expected 00", d); end
        bus_write(16'hD003, 8'h01, st);
        checks++; if (bus_if.IRQ !== 1'b1) begin errors++; $display("FAIL timer_stat_clr: got %b, expected 1", bus_if.IRQ); end
    endtask

    task automatic test_timer_auto();
        logic [7:0] d; logic ok; int st;
        bus_write(16'hD002, 8'h07, st);
        ok = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (bus_if.IRQ !== 1'b1) ok = 1'b0; end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL auto_early_irq: got early IRQ low, expected high 3 cycles"); end
        @(posedge clk); #1;
        checks++; if (bus_if.IRQ !== 1'b0) begin errors++; $display("FAIL auto_irq_first: got %b, expected 0", bus_if.IRQ); end
        for (int n = 0; n < 2; n++) begin
            bus_write(16'hD003, 8'h01, st);
            checks++; if (bus_if.IRQ !== 1'b1) begin errors++; $display("FAIL auto_clr_%0d: got %b, expected 1", n, bus_if.IRQ); end
            @(posedge clk); #1;
            checks++; if (bus_if.IRQ !== 1'b0) begin errors++; $display("FAIL auto_reassert_%0d: got %b, expected 0", n, bus_if.IRQ); end
        end
        bus_write(16'hD002, 8'h00, st);
        bus_write(16'hD003, 8'h01, st);
        bus_read(16'hD003, d, st);
        checks++; if (d !== 8'h00 || bus_if.IRQ !== 1'b1) begin errors++; $display("FAIL auto_stop: got stat %h irq %b, expected 00 1", d, bus_if.IRQ); end
    endtask

    task automatic test_set_wins();
        logic [7:0] d; int st;
        bus_write(16'hD000, 8'h00, st);
        bus_write(16'hD002, 8'h07, st);
        bus_write(16'hD003, 8'h01, st);
        checks++; if (bus_if.IRQ !== 1'b0) begin errors++; $display("FAIL set_wins_irq: got %b, expected 0", bus_if.IRQ); end
        bus_read(16'hD003, d, st);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL set_wins_stat: got %h, expected 01", d); end
        bus_write(16'hD002, 8'h00, st);
        bus_write(16'hD003, 8'h01, st);
        bus_read(16'hD003, d, st);
        checks++; if (d !== 8'h00 || bus_if.IRQ !== 1'b1) begin errors++; $display("FAIL set_wins_stop: got stat %h irq %b, expected 00 1", d, bus_if.IRQ); end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] d; int st;
        bus_if.add_bus  = 16'hD000;
        bus_if.d_out    = 8'h55;
        bus_if.write_en = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.rdy !== 1'b0) begin errors++; $display("FAIL midwait_idle_rdy: got %b, expected 0", bus_if.rdy); end
        @(negedge clk);
        checks++; if (bus_if.rdy !== 1'b0) begin errors++; $display("FAIL midwait_wait_rdy: got %b, expected 0", bus_if.rdy); end
        #1 reset = 1'b0;
        #1;
        checks++; if (bus_if.rdy !== 1'b1) begin errors++; $display("FAIL midwait_reset_rdy: got %b, expected 1", bus_if.rdy); end
        checks++; if (bus_if.d_in !== 8'hFF) begin errors++; $display("FAIL midwait_reset_d_in: got %h, expected ff", bus_if.d_in); end
        bus_if.add_bus  = IDLE_ADDR;
        bus_if.write_en = 1'b1;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        bus_read(16'h0123, d, st);
        checks++; if (d !== 8'hA5 || st !== 0) begin errors++; $display("FAIL ram_kept_idle: got %h stall %0d, expected a5 0", d, st); end
        bus_write(16'hD002, 8'h01, st);
        bus_read(16'hD000, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL midwait_reload: got %h, expected 00", d); end
        bus_read(16'hD002, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL midwait_ctrl: got %h, expected 00", d); end
    endtask

`ifdef MOS6502_RESP_WDOG_EN
    task automatic test_watchdog();
        logic [7:0] d; int st; int first; int lows;
        first = -1; lows = 0;
        reset = 1'b0; #1;
        @(negedge clk); reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus_if.NMI === 1'b0) begin
                if (first < 0) first = k;
                lows++;
            end
        end
        checks++; if (first !== 16) begin errors++; $display("FAIL wdog_start: got %0d, expected 16", first); end
        checks++; if (lows !== 8) begin errors++; $display("FAIL wdog_width: got %0d, expected 8", lows); end
        reset = 1'b0; #1;
        @(negedge clk); reset = 1'b1;
        nmi_low_seen = 1'b0; mon_en = 1'b1;
        repeat (6) begin
            bus_write(16'hD004, 8'h00, st);
            repeat (7) @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        checks++; if (nmi_low_seen !== 1'b0) begin errors++; $display("FAIL wdog_kicked: got NMI low, expected stays 1"); end
        bus_read(16'hD004, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL wdog_rd: got %h, expected 00", d); end
    endtask
`else
    task automatic test_no_watchdog();
        logic [7:0] d; int st;
        nmi_low_seen = 1'b0; mon_en = 1'b1;
        bus_write(16'hD004, 8'h9C, st);
        repeat (40) @(posedge clk);
        #1;
        mon_en = 1'b0;
        checks++; if (nmi_low_seen !== 1'b0) begin errors++; $display("FAIL nmi_tied: got NMI low, expected 1"); end
        bus_read(16'hD004, d, st);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL off4_rd: got %h, expected 00", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_vector();
        test_ram();
        test_wait_states();
        test_timer();
        test_timer_auto();
        test_set_wins();
        test_reset_mid_wait();
`ifdef MOS6502_RESP_WDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
